// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative multiply/divide unit that owns the HI/LO register pair.
// It executes mult, multu, div, divu, mthi and mtlo. Each operation is accepted
// over a valid/ready handshake, and completion is signalled by a one-cycle done pulse.
//
// Optional feature: define MDU_FAST_MUL_EN to use a single-cycle multiplier
// for mult/multu. Without it, mult/multu use a radix-2 shift-add, and the
// latency is WIDTH+1 cycles. Division is always restoring, with a latency of
// WIDTH+1 cycles.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while IDLE)
//   req_op              000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   req_src1/req_src2   operands (src1 also carries mthi/mtlo data)
//   cancel              flushes an in-flight operation (no write, no done)
//   busy                an operation is in flight
//   done                one-cycle completion pulse; HI/LO already updated
//   hi/lo               HI and LO registers
module hilo_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d, orig_q, orig_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, is_div_q, is_div_d;

    logic               signed_op, neg1, neg2;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     div_trial, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;
    logic               last_iter;

    assign signed_op = (req_op == OP_MULT) || (req_op == OP_DIV);
    assign neg1      = signed_op && req_src1[WIDTH-1];
    assign neg2      = signed_op && req_src2[WIDTH-1];
    assign abs1      = neg1 ? -req_src1 : req_src1;
    assign abs2      = neg2 ? -req_src2 : req_src2;

    // Restoring step: the partial remainder is in acc[2W-1:W], and the dividend
    // bits shift out of acc[W-1:0] while quotient bits shift in.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, op2_q};

    assign prod_fix  = neg_q ? -acc_q : acc_q;
    assign quo       = acc_q[WIDTH-1:0];
    assign rem       = acc_q[2*WIDTH-1:WIDTH];
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod_abs, prod_fast;
    assign prod_abs  = {{WIDTH{1'b0}}, op1_q} * {{WIDTH{1'b0}}, op2_q};
    assign prod_fast = neg_q ? -prod_abs : prod_abs;
`else
    // Shift-add step: the multiplier sits in acc[W-1:0] and is consumed LSB first.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op1_q} : '0);
`endif

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        orig_d   = orig_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        is_div_d = is_div_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d    = '0;
                    op1_d    = abs1;
                    op2_d    = abs2;
                    orig_d   = req_src1;
                    neg_d    = neg1 ^ neg2;
                    rneg_d   = neg1;
                    dz_d     = (req_src2 == '0);
                    is_div_d = 1'b0;
                    case (req_op)
                        OP_MULT, OP_MULTU: begin
                            acc_d   = {{WIDTH{1'b0}}, abs2};
                            state_d = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d    = {{WIDTH{1'b0}}, abs1};
                            is_div_d = 1'b1;
                            state_d  = DIV;
                        end
                        OP_MTHI: begin
                            hi_d   = req_src1;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = req_src1;
                            done_d = 1'b1;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            MUL: begin
`ifdef MDU_FAST_MUL_EN
                hi_d    = prod_fast[2*WIDTH-1:WIDTH];
                lo_d    = prod_fast[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
`else
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = FIX;
`endif
            end
            DIV: begin
                acc_d = {(div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    // A zero divisor gets an explicit result: sign fix-up on the
                    // all-ones quotient would corrupt it for signed operands.
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = orig_q;
                    end else begin
                        lo_d = neg_q  ? -quo : quo;
                        hi_d = rneg_q ? -rem : rem;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A flush overrides any write or completion from a non-idle state.
        if (cancel && (state_q != IDLE)) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            orig_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            orig_q   <= orig_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            is_div_q <= is_div_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: a table of operations with hand-computed HI/LO
// and latency, followed by sequences for back-to-back, cancel and reset cases.
module tb_hilo_mdu;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_op = 3'b000;
    logic [W-1:0] req_src1 = '0;
    logic [W-1:0] req_src2 = '0;
    logic         cancel = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    hilo_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .cancel(cancel),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge. Issues one request, then scrambles the inputs
    // so that latching is exercised. Returns the number of edges after accept
    // until done is seen.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_src1  = ~a;
        req_src2  = ~b;
        req_op    = 3'b111;
        lat = 0;
        if (!done) begin
            chk("busy_inflight", {31'b0, busy}, 32'd1);
            chk("ready_inflight", {31'b0, req_ready}, 32'd0);
        end
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        int           lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int lat;
        int n;
        int dcount;
        logic [W-1:0] shi, slo;

        vecs[0]  = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
        vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        vecs[3]  = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DIV_LAT};
        vecs[4]  = '{3'b011, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, DIV_LAT};
        vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
        vecs[6]  = '{3'b010, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, DIV_LAT};
        vecs[7]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};
        vecs[8]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT};
        vecs[9]  = '{3'b100, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'hFFFFFFFD, 0};
        vecs[10] = '{3'b101, 32'h12345678, 32'h00000000, 32'hDEADBEEF, 32'h12345678, 0};
        vecs[11] = '{3'b110, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h12345678, 0};
        vecs[12] = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MUL_LAT};
        vecs[13] = '{3'b000, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, MUL_LAT};

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        // Table-driven operations
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].elo);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
        end

        // multu, then mthi accepted in the done cycle
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        chk("b2b_lat", lat, MUL_LAT);
        chk("b2b_ready_in_done", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = 3'b100; req_src1 = 32'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_hi", hi, 32'h1234);
        chk("b2b_lo", lo, 32'h1);
        chk("b2b_done", {31'b0, done}, 32'd1);
        @(posedge clk); #1;

        // cancel during the 10th DIV cycle
        shi = hi; slo = lo;
        req_valid = 1'b1; req_op = 3'b011; req_src1 = 32'd100; req_src2 = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cdiv_busy", {31'b0, busy}, 32'd0);
        chk("cdiv_ready", {31'b0, req_ready}, 32'd1);
        chk("cdiv_done", {31'b0, done}, 32'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("cdiv_nodone", dcount, 0);
        chk("cdiv_hi", hi, shi);
        chk("cdiv_lo", lo, slo);

        // cancel coinciding with the FIX edge
        req_valid = 1'b1; req_op = 3'b010; req_src1 = 32'd50; req_src2 = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1 cancel = 1'b1;
        chk("cfix_busy_before", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cfix_done", {31'b0, done}, 32'd0);
        chk("cfix_busy", {31'b0, busy}, 32'd0);
        chk("cfix_hi", hi, shi);
        chk("cfix_lo", lo, slo);
        @(posedge clk); #1;
        chk("cfix_done_late", {31'b0, done}, 32'd0);

        // reset during a multiply
        req_valid = 1'b1; req_op = 3'b001; req_src1 = 32'd9; req_src2 = 32'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifndef MDU_FAST_MUL_EN
        repeat (5) @(posedge clk);
        #1;
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rmul_hi", hi, '0);
        chk("rmul_lo", lo, '0);
        chk("rmul_busy", {31'b0, busy}, 32'd0);
        chk("rmul_done", {31'b0, done}, 32'd0);
        chk("rmul_ready", {31'b0, req_ready}, 32'd1);
        run_op(3'b101, 32'h000000A5, 32'h0, lat);
        chk("rmul_mtlo_lat", lat, 0);
        chk("rmul_mtlo_lo", lo, 32'hA5);
        chk("rmul_mtlo_hi", hi, '0);
        n = 0;
        while (n < 40 && !done) begin
            @(posedge clk); #1;
            n++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
